// File: rtl/banked_register_file.sv
// Register file with shared R0..R12, user/irq banked R13/R14 and a dedicated PC (R15).
// Reads are combinational with write-data bypass; R15 reads return the pipeline-visible PC.
module banked_register_file #(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_addr1,
    input  logic [3:0]        rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              pc_wr_en,
    input  logic [DATA_W-1:0] pc_wr_data,
    input  logic              pc_inc_en,
    input  logic              mode,
    output logic [DATA_W-1:0] pc_out
);

    localparam logic [DATA_W-1:0] ALIGN_MASK = ~DATA_W'(3);
    localparam logic [DATA_W-1:0] PC_INC     = DATA_W'(PC_STEP);
    localparam logic [DATA_W-1:0] PC_AHEAD   = DATA_W'(2 * PC_STEP);

    logic [DATA_W-1:0] gpr_q [13];
    logic [DATA_W-1:0] bank_q [4];
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;

    // Banked slot index: {mode, address is R14}.
    function automatic logic [1:0] bank_idx(input logic m, input logic [3:0] a);
        return {m, a == 4'd14};
    endfunction

    function automatic logic [DATA_W-1:0] read_port(input logic [3:0] a);
        if (a == 4'd15) begin
            return pc_q + PC_AHEAD;
        end
        if (wr_en && (wr_addr == a)) begin
            return wr_data;
        end
        if (a < 4'd13) begin
            return gpr_q[a];
        end
        return bank_q[bank_idx(mode, a)];
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
    end

    always_comb begin
        pc_d = pc_q;
        if (pc_wr_en) begin
            pc_d = pc_wr_data & ALIGN_MASK;
        end else if (wr_en && (wr_addr == 4'd15)) begin
            pc_d = wr_data & ALIGN_MASK;
        end else if (pc_inc_en) begin
            pc_d = (pc_q + PC_INC) & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 13; i++) begin
                gpr_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= '0;
            end
            pc_q <= RESET_PC & ALIGN_MASK;
        end else begin
            pc_q <= pc_d;
            if (wr_en) begin
                if (wr_addr < 4'd13) begin
                    gpr_q[wr_addr] <= wr_data;
                end else if (wr_addr != 4'd15) begin
                    bank_q[bank_idx(mode, wr_addr)] <= wr_data;
                end
            end
        end
    end

    assign pc_out = pc_q;

endmodule

// File: doc/banked_register_file.md
BANKED_REGISTER_FILE -- requirements
Module: banked_register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of every register, write datum and read datum.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-003 The block SHALL have parameter PC_STEP, default 4, giving the PC auto-increment amount.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port wr_en, input, 1 bit: general register write strobe.
REQ-007 The block SHALL have port wr_addr, input, 4 bits: architectural write address R0..R15.
REQ-008 The block SHALL have port wr_data, input, DATA_W bits: general write datum.
REQ-009 The block SHALL have ports rd_addr1 and rd_addr2, input, 4 bits each: read-port addresses.
REQ-010 The block SHALL have ports rd_data1 and rd_data2, output, DATA_W bits each: read-port data.
REQ-011 The block SHALL have port pc_wr_en, input, 1 bit: dedicated PC load strobe.
REQ-012 The block SHALL have port pc_wr_data, input, DATA_W bits: dedicated PC load value.
REQ-013 The block SHALL have port pc_inc_en, input, 1 bit: PC advance request.
REQ-014 The block SHALL have port mode, input, 1 bit: 0 = user bank, 1 = irq bank.
REQ-015 The block SHALL have port pc_out, output, DATA_W bits: current PC register value.

Function
REQ-016 Storage SHALL be: R0..R12 (shared), R13/R14 user copies, R13/R14 irq copies, and a separate PC register (architectural R15).
REQ-017 Accesses to addresses 13 and 14 SHALL select the bank given by the current-cycle mode value, for both reads and writes; all other addresses ignore mode.
REQ-018 Reads SHALL be combinational with zero-cycle latency.
REQ-019 Reads of address 15 SHALL return pc_out + 2*PC_STEP, modulo 2^DATA_W (pipeline-visible PC).
REQ-020 Bypass: when wr_en=1 and wr_addr equals rd_addrN (after bank resolution), with the address not 15, rd_dataN SHALL return wr_data in the same cycle.
REQ-021 Writes to R0..R14 SHALL take effect at the rising edge where wr_en=1.
REQ-022 PC next-value priority per edge SHALL be: pc_wr_en -> pc_wr_data; else wr_en with wr_addr=15 -> wr_data; else pc_inc_en -> pc_out + PC_STEP; else hold.
REQ-023 Any value loaded into the PC SHALL have its two LSBs forced to zero.
REQ-024 The PC increment SHALL wrap modulo 2^DATA_W, with no saturation and no flag.
REQ-025 A read of address 15 in a cycle that also writes the PC SHALL return the old PC + 2*PC_STEP; there is no bypass on R15.
REQ-026 A mode change SHALL take effect combinationally, with no stored mode state; banked contents persist across mode switches.
REQ-027 The block SHALL contain no X-producing paths: every address 0..15 maps to defined storage.

Reset
REQ-028 While rst_n=0, every general and banked register SHALL be 0 and the PC SHALL be RESET_PC with bits [1:0] cleared, regardless of clk.
REQ-029 Reset assertion mid-write SHALL win: the write is discarded.
REQ-030 The first state update SHALL occur on the first rising clk edge after rst_n deasserts.

Verification
REQ-031 Reset, then rd_addr1=5, rd_addr2=15 -> rd_data1=0, rd_data2=RESET_PC+8 (0x00000008 with defaults).
REQ-032 wr_en=1, wr_addr=1, wr_data=0xFFFFFFFF with rd_addr1=1 -> rd_data1=0xFFFFFFFF in the same cycle (bypass) and after the edge with wr_en=0.
REQ-033 mode=0 write R13=0x1111; mode=1 write R13=0x2222 -> reading R13 returns 0x1111 under mode=0 and 0x2222 under mode=1.
REQ-034 pc_wr_en=1 with 0x1003, wr_en=1 to addr 15 with 0x5000, and pc_inc_en=1, all in one cycle -> pc_out=0x1000 after the edge.
REQ-035 PC loaded with 0xFFFFFFFC, then pc_inc_en=1 for one edge -> pc_out=0x00000000.
REQ-036 rst_n pulsed low between edges during a pending write of R2=0xABCD -> R2 reads 0 and pc_out=RESET_PC immediately, without waiting for clk.
